// File: rtl/axis_downsizer_pkg.sv
// Shared helpers for the AXI-Stream N*W -> W downsizer (lane mask arithmetic).
// Optional feature macro: AXIS_DOWNSIZER_KEEP_EN (per-lane tkeep skipping).
package axis_downsizer_pkg;

    localparam int unsigned MAX_N      = 32;
    localparam int unsigned DEF_W      = 40;
    localparam int unsigned DEF_N      = 2;
    localparam int unsigned LANE_IDX_W = $clog2(DEF_N);

    // Index width for an N-lane cursor; never zero so N=1 builds still elaborate.
    function automatic int unsigned lane_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_N-1:0] onehot_lowest(input logic [MAX_N-1:0] mask);
        return mask & (~mask + MAX_N'(1));
    endfunction

    function automatic logic is_single(input logic [MAX_N-1:0] mask);
        return (mask != '0) && ((mask & (mask - MAX_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/axis_downsizer_sva.sv
// Protocol checks bound into every axis_downsizer instance.
// The keep==0-with-tlast check exists only under AXIS_DOWNSIZER_KEEP_EN.
module axis_downsizer_sva #(
    parameter int unsigned W = 40,
    parameter int unsigned N = 2
) (
    input logic         aclk,
    input logic         areset,
`ifdef AXIS_DOWNSIZER_KEEP_EN
    input logic         in_tvalid,
    input logic         in_tlast,
    input logic [N-1:0] in_tkeep,
`endif
    input logic         in_tready,
    input logic         out_tvalid,
    input logic         out_tready,
    input logic         out_tlast,
    input logic [W-1:0] out_tdata,
    input logic         buf_valid_q
);

    a_stall_stable: assert property (@(posedge aclk) disable iff (areset)
        (out_tvalid && !out_tready) |=> (out_tvalid && $stable(out_tdata) && $stable(out_tlast)));

    a_ready_when_empty: assert property (@(posedge aclk) disable iff (areset)
        !buf_valid_q |-> in_tready);

`ifdef AXIS_DOWNSIZER_KEEP_EN
    // An all-empty beat carries no lane to hang tlast on, so the packet end would vanish.
    a_no_empty_last: assert property (@(posedge aclk) disable iff (areset)
        (in_tvalid && in_tready && (in_tkeep == '0)) |-> !in_tlast);
`endif

endmodule

bind axis_downsizer axis_downsizer_sva #(.W(W), .N(N)) u_sva (
    .aclk        (aclk),
    .areset      (areset),
`ifdef AXIS_DOWNSIZER_KEEP_EN
    .in_tvalid   (in_tvalid),
    .in_tlast    (in_tlast),
    .in_tkeep    (in_tkeep),
`endif
    .in_tready   (in_tready),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_tlast   (out_tlast),
    .out_tdata   (out_tdata),
    .buf_valid_q (buf_valid_q)
);

// File: rtl/axis_lane_pick.sv
// Picks the lowest remaining lane of a mask: one-hot select, binary index, final-lane flag.
// Purely combinational.
module axis_lane_pick
    import axis_downsizer_pkg::*;
#(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = lane_idx_w(N)
) (
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     sel_oh_c,
    output logic [IDX_W-1:0] sel_idx_c,
    output logic             final_c
);

    always_comb begin
        sel_oh_c  = N'(onehot_lowest(MAX_N'(mask)));
        final_c   = is_single(MAX_N'(mask));
        sel_idx_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (sel_oh_c[i]) begin
                sel_idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axis_downsizer.sv
// AXI-Stream width converter: N*W-bit input beats out as N W-bit beats, lowest lane first.
// Define AXIS_DOWNSIZER_KEEP_EN to add in_tkeep and skip lanes whose keep bit is clear.
module axis_downsizer
    import axis_downsizer_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned N = DEF_N
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [N*W-1:0] in_tdata,
`ifdef AXIS_DOWNSIZER_KEEP_EN
    input  logic [N-1:0]   in_tkeep,
`endif
    input  logic           in_tlast,
    input  logic           in_tvalid,
    output logic           in_tready,
    output logic [W-1:0]   out_tdata,
    output logic           out_tlast,
    output logic           out_tvalid,
    input  logic           out_tready
);

    localparam int unsigned IDX_W = lane_idx_w(N);

    logic [N*W-1:0]   buf_data_q, buf_data_d;
    logic [N-1:0]     buf_mask_q, buf_mask_d;
    logic             buf_last_q, buf_last_d;
    logic             buf_valid_q, buf_valid_d;

    logic [N-1:0]     sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic             final_lane;
    logic [N-1:0]     load_mask_c;
    logic             in_fire_c;
    logic             out_fire_c;

`ifdef AXIS_DOWNSIZER_KEEP_EN
    assign load_mask_c = in_tkeep;
`else
    assign load_mask_c = {N{1'b1}};
`endif

    axis_lane_pick #(.N(N)) u_lane_pick (
        .mask      (buf_mask_q),
        .sel_oh_c  (sel_oh),
        .sel_idx_c (sel_idx),
        .final_c   (final_lane)
    );

    // Output side is a pure function of the holding register; only in_tready sees out_tready.
    always_comb begin
        in_tready  = ~buf_valid_q | (out_tready & final_lane);
        out_tvalid = buf_valid_q;
        out_tdata  = buf_data_q[32'(sel_idx) * W +: W];
        out_tlast  = buf_last_q & final_lane;
        in_fire_c  = in_tvalid & in_tready;
        out_fire_c = buf_valid_q & out_tready;
    end

    // Next state: retire the presented lane, then a same-cycle accept overwrites the register.
    always_comb begin
        buf_data_d  = buf_data_q;
        buf_mask_d  = buf_mask_q;
        buf_last_d  = buf_last_q;
        buf_valid_d = buf_valid_q;
        if (out_fire_c) begin
            buf_mask_d = buf_mask_q & ~sel_oh;
            if (final_lane) begin
                buf_valid_d = 1'b0;
            end
        end
        if (in_fire_c) begin
            buf_data_d  = in_tdata;
            buf_mask_d  = load_mask_c;
            buf_last_d  = in_tlast;
            buf_valid_d = |load_mask_c;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            buf_data_q  <= '0;
            buf_mask_q  <= '0;
            buf_last_q  <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            buf_data_q  <= buf_data_d;
            buf_mask_q  <= buf_mask_d;
            buf_last_q  <= buf_last_d;
            buf_valid_q <= buf_valid_d;
        end
    end

endmodule

// File: tb/tb_axis_downsizer.sv
// Bench for axis_downsizer: W=8/N=4 instance against a lane-queue model, plus a W=40/N=2 instance.
module tb_axis_downsizer;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned WW = 40;
    localparam int unsigned WN = 2;
`ifdef AXIS_DOWNSIZER_KEEP_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic           aclk = 1'b0;
    logic           areset;
    logic [N*W-1:0] in_tdata;
    logic [N-1:0]   in_tkeep;
    logic           in_tlast, in_tvalid, in_tready;
    logic [W-1:0]   out_tdata;
    logic           out_tlast, out_tvalid, out_tready;

    logic [WN*WW-1:0] w_in_tdata;
    logic [WN-1:0]    w_in_tkeep;
    logic             w_in_tlast, w_in_tvalid, w_in_tready;
    logic [WW-1:0]    w_out_tdata;
    logic             w_out_tlast, w_out_tvalid, w_out_tready;

    always #5 aclk = ~aclk;

    axis_downsizer #(.W(W), .N(N)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .in_tdata   (in_tdata),
`ifdef AXIS_DOWNSIZER_KEEP_EN
        .in_tkeep   (in_tkeep),
`endif
        .in_tlast   (in_tlast),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    axis_downsizer #(.W(WW), .N(WN)) dut_w (
        .aclk       (aclk),
        .areset     (areset),
        .in_tdata   (w_in_tdata),
`ifdef AXIS_DOWNSIZER_KEEP_EN
        .in_tkeep   (w_in_tkeep),
`endif
        .in_tlast   (w_in_tlast),
        .in_tvalid  (w_in_tvalid),
        .in_tready  (w_in_tready),
        .out_tdata  (w_out_tdata),
        .out_tlast  (w_out_tlast),
        .out_tvalid (w_out_tvalid),
        .out_tready (w_out_tready)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } lane_t;

    beat_t in_q[$];
    lane_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    fire_first, fire_last;

    // Model: a beat becomes its kept lanes in ascending order; tlast rides on the highest kept lane.
    function automatic void model_push(input beat_t b);
        int top = -1;
        lane_t l;
        for (int i = 0; i < 4; i++) if (b.keep[i]) top = i;
        for (int i = 0; i < 4; i++) begin
            if (b.keep[i]) begin
                l.data = b.data[i*8 +: 8];
                l.last = b.last && (i == top);
                exp_q.push_back(l);
            end
        end
    endfunction

    function automatic beat_t rand_beat(input bit rand_keep);
        beat_t b;
        b.data = $urandom;
        b.keep = rand_keep ? 4'($urandom) : 4'hF;
        b.last = 1'($urandom_range(1));
        if (b.keep == 4'h0) b.last = 1'b0;
        return b;
    endfunction

    task automatic drive_head();
        if (in_q.size() > 0) begin
            in_tvalid = 1'b1;
            in_tdata  = in_q[0].data;
            in_tkeep  = in_q[0].keep;
            in_tlast  = in_q[0].last;
        end else begin
            in_tvalid = 1'b0;
        end
    endtask

    // Streams in_q through the DUT with random backpressure, scoring every cycle against the model.
    task automatic run_beats(input int stall_pct);
        int  cyc = 0;
        bit  exp_ready;
        lane_t l;
        fire_first = -1;
        fire_last  = -1;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 2000) begin
            @(posedge aclk); #1;
            drive_head();
            out_tready = (int'($urandom_range(99)) >= stall_pct);
            @(negedge aclk);
            cyc++;
            n_checks++;
            if (out_tvalid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL out_tvalid cyc=%0d: got %b expected %b", cyc, out_tvalid, exp_q.size() != 0);
            end
            exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_tready);
            n_checks++;
            if (in_tready !== exp_ready) begin
                n_fail++;
                $display("FAIL in_tready cyc=%0d: got %b expected %b", cyc, in_tready, exp_ready);
            end
            if (exp_q.size() > 0) begin
                l = exp_q[0];
                n_checks++;
                if (out_tdata !== l.data || out_tlast !== l.last) begin
                    n_fail++;
                    $display("FAIL lane cyc=%0d: got data=%h last=%b expected data=%h last=%b",
                             cyc, out_tdata, out_tlast, l.data, l.last);
                end
                if (out_tready) begin
                    void'(exp_q.pop_front());
                    if (fire_first < 0) fire_first = cyc;
                    fire_last = cyc;
                end
            end
            if (in_tvalid && in_tready && in_q.size() > 0) model_push(in_q.pop_front());
        end
        @(posedge aclk); #1;
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        n_checks++;
        if (in_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain timeout: got %0d beats %0d lanes pending expected 0 0", in_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '1; in_tlast = 1'b0; out_tready = 1'b1;
        w_in_tvalid = 1'b0; w_in_tdata = '0; w_in_tkeep = '1; w_in_tlast = 1'b0; w_out_tready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (out_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset out_tvalid: got %b expected 0", out_tvalid); end
        n_checks++; if (out_tlast !== 1'b0) begin n_fail++; $display("FAIL reset out_tlast: got %b expected 0", out_tlast); end
        n_checks++; if (out_tdata !== 8'h00) begin n_fail++; $display("FAIL reset out_tdata: got %h expected 00", out_tdata); end
        n_checks++; if (in_tready !== 1'b1) begin n_fail++; $display("FAIL reset in_tready: got %b expected 1", in_tready); end
        n_checks++; if (w_out_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset w_out_tvalid: got %b expected 0", w_out_tvalid); end
        n_checks++; if (w_out_tdata !== '0) begin n_fail++; $display("FAIL reset w_out_tdata: got %h expected 0", w_out_tdata); end
        n_checks++; if (w_in_tready !== 1'b1) begin n_fail++; $display("FAIL reset w_in_tready: got %b expected 1", w_in_tready); end
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] b = 32'h44332211;
        out_tready = 1'b1;
        @(posedge aclk); #1;
        in_tvalid = 1'b1; in_tdata = b; in_tkeep = 4'hF; in_tlast = 1'b1;
        @(negedge aclk);
        n_checks++; if (in_tready !== 1'b1) begin n_fail++; $display("FAIL single pre-accept in_tready: got %b expected 1", in_tready); end
        @(posedge aclk); #1;
        in_tvalid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge aclk);
            n_checks++;
            if (out_tvalid !== 1'b1 || out_tdata !== b[j*8 +: 8] || out_tlast !== (j == 3) || in_tready !== (j == 3)) begin
                n_fail++;
                $display("FAIL single lane %0d: got v=%b d=%h l=%b r=%b expected v=1 d=%h l=%b r=%b",
                         j, out_tvalid, out_tdata, out_tlast, in_tready, b[j*8 +: 8], j == 3, j == 3);
            end
        end
        @(negedge aclk);
        n_checks++; if (out_tvalid !== 1'b0) begin n_fail++; $display("FAIL single drained out_tvalid: got %b expected 0", out_tvalid); end
    endtask

    task automatic test_back_to_back();
        beat_t b;
        b.keep = 4'hF;
        b.data = 32'h04030201; b.last = 1'b0; in_q.push_back(b);
        b.data = 32'h08070605; b.last = 1'b1; in_q.push_back(b);
        run_beats(0);
        n_checks++;
        if (fire_first < 0 || fire_last - fire_first != 7) begin
            n_fail++;
            $display("FAIL back_to_back span: got %0d expected 7", fire_last - fire_first);
        end
    endtask

    task automatic test_stall();
        beat_t b;
        b.data = 32'hDDCCBBAA; b.keep = 4'hF; b.last = 1'b1;
        in_q.push_back(b);
        for (int i = 0; i < 6; i++) in_q.push_back(rand_beat(1'b0));
        run_beats(50);
    endtask

    task automatic test_keep();
        beat_t b;
        b.data = 32'h44332211; b.keep = 4'b1010; b.last = 1'b1; in_q.push_back(b);
        b.data = 32'h99999999; b.keep = 4'b0000; b.last = 1'b0; in_q.push_back(b);
        b.data = 32'hA1B2C3D4; b.keep = 4'b0110; b.last = 1'b1; in_q.push_back(b);
        b.data = 32'h55555555; b.keep = 4'b0000; b.last = 1'b0; in_q.push_back(b);
        for (int i = 0; i < 12; i++) in_q.push_back(rand_beat(1'b1));
        run_beats(30);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) in_q.push_back(rand_beat(KEEP));
        run_beats(25);
    endtask

    task automatic test_reset_mid();
        beat_t b;
        out_tready = 1'b1;
        @(posedge aclk); #1;
        in_tvalid = 1'b1; in_tdata = 32'h44332211; in_tkeep = 4'hF; in_tlast = 1'b1;
        @(posedge aclk); #1;
        in_tvalid = 1'b0;
        @(negedge aclk);
        n_checks++; if (out_tdata !== 8'h11) begin n_fail++; $display("FAIL reset_mid lane0: got %h expected 11", out_tdata); end
        @(negedge aclk);
        n_checks++; if (out_tdata !== 8'h22) begin n_fail++; $display("FAIL reset_mid lane1: got %h expected 22", out_tdata); end
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (out_tvalid !== 1'b0 || in_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid after: got v=%b r=%b expected v=0 r=1", out_tvalid, in_tready);
        end
        exp_q.delete();
        b.data = 32'h88776655; b.keep = 4'hF; b.last = 1'b1;
        in_q.push_back(b);
        run_beats(0);
    endtask

    task automatic test_wide();
        w_out_tready = 1'b0;
        @(posedge aclk); #1;
        w_in_tvalid = 1'b1; w_in_tdata = {40'hB, 40'hA}; w_in_tkeep = 2'b11; w_in_tlast = 1'b1;
        @(negedge aclk);
        n_checks++; if (w_in_tready !== 1'b1) begin n_fail++; $display("FAIL wide pre-accept ready: got %b expected 1", w_in_tready); end
        @(posedge aclk); #1;
        w_in_tvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            n_checks++;
            if (w_out_tvalid !== 1'b1 || w_out_tdata !== 40'hA || w_out_tlast !== 1'b0 || w_in_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL wide stall A: got v=%b d=%h l=%b r=%b expected v=1 d=a l=0 r=0",
                         w_out_tvalid, w_out_tdata, w_out_tlast, w_in_tready);
            end
        end
        @(posedge aclk); #1;
        w_out_tready = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (w_out_tdata !== 40'hA || w_in_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL wide A ready: got d=%h r=%b expected d=a r=0", w_out_tdata, w_in_tready);
        end
        @(negedge aclk);
        n_checks++;
        if (w_out_tvalid !== 1'b1 || w_out_tdata !== 40'hB || w_out_tlast !== 1'b1 || w_in_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL wide B: got v=%b d=%h l=%b r=%b expected v=1 d=b l=1 r=1",
                     w_out_tvalid, w_out_tdata, w_out_tlast, w_in_tready);
        end
        @(negedge aclk);
        n_checks++; if (w_out_tvalid !== 1'b0) begin n_fail++; $display("FAIL wide drained: got %b expected 0", w_out_tvalid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
`ifdef AXIS_DOWNSIZER_KEEP_EN
        test_keep();
`endif
        test_random();
        test_reset_mid();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
